// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-ported register file with byte enables and hardware clear
//
// Purpose:
//   NUM_REGS x DATA_W register file with NRD combinational read ports and NWR
//   byte-enabled write ports. Entry 0 reads as zero and ignores writes. After
//   reset, or on a clear request, an INIT sweep zeroes one entry per cycle
//   (NUM_REGS cycles). Writes are ignored and all reads return zero until the
//   sweep finishes and the file enters RUN.
//
// Ports:
//   clk    in   1            rising-edge clock
//   resetn in   1            asynchronous active-low reset
//   clear  in   1            synchronous request (in RUN) to re-zero all entries
//   raddr  in   NRD*AW       packed read addresses, port i at [i*AW +: AW]
//   rdata  out  NRD*DATA_W   packed read data, port i at [i*DATA_W +: DATA_W]
//   we     in   NWR*BE_W     packed byte enables, port j at [j*BE_W +: BE_W]
//   waddr  in   NWR*AW       packed write addresses
//   wdata  in   NWR*DATA_W   packed write data
//   ready  out  1            high while in RUN (writes accepted)
//
// Configuration:
//   REGFILE_BYPASS_EN  when defined, a read that matches an active write in the
//                      same cycle returns the incoming bytes (highest write
//                      port wins per byte); otherwise reads see stored data only.
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int  NUM_REGS = 64,
    parameter int  DATA_W   = 32,
    parameter int  NRD      = 5,
    parameter int  NWR      = 2,
    localparam int AW       = $clog2(NUM_REGS),
    localparam int BE_W     = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    input  logic [NWR*BE_W-1:0]   we,
    input  logic [NWR*AW-1:0]     waddr,
    input  logic [NWR*DATA_W-1:0] wdata,
    output logic                  ready
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = AW'(NUM_REGS - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [AW-1:0]           r_cnt;
    logic [AW-1:0]           w_cnt_nxt;
    logic                    r_ready;
    logic                    w_ready_nxt;
    logic [DATA_W-1:0]       r_mem [NUM_REGS];
    logic [NRD*DATA_W-1:0]   w_rdata;

    // State register: FSM state, sweep counter and registered ready flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Next-state logic: sweep NUM_REGS entries in INIT, leave RUN on clear.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + AW'(1'b1);
                end
            end
            ST_RUN: begin
                if (clear) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: ready is registered, so it follows the state being entered.
    always_comb begin
        w_ready_nxt = 1'b0;
        case (w_state_nxt)
            ST_RUN:  w_ready_nxt = 1'b1;
            ST_INIT: w_ready_nxt = 1'b0;
            default: w_ready_nxt = 1'b0;
        endcase
    end

    // Storage array: INIT zeroes entry cnt; RUN applies byte writes in ascending
    // port order so the highest-indexed port's assignment lands last per byte.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (we[j*BE_W + b] && (waddr[j*AW +: AW] != '0)) begin
                        r_mem[waddr[j*AW +: AW]][b*8 +: 8] <= wdata[j*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read ports: zero outside RUN and for address 0, optional write bypass.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0]     w_ra;
            logic [DATA_W-1:0] w_word;
            w_ra   = raddr[i*AW +: AW];
            w_word = '0;
            if ((r_state == ST_RUN) && (w_ra != '0)) begin
                w_word = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (we[j*BE_W + b] && (waddr[j*AW +: AW] == w_ra)) begin
                            w_word[b*8 +: 8] = wdata[j*DATA_W + b*8 +: 8];
                        end else begin
                            w_word[b*8 +: 8] = w_word[b*8 +: 8];
                        end
                    end
                end
`endif
            end else begin
                w_word = '0;
            end
            w_rdata[i*DATA_W +: DATA_W] = w_word;
        end
    end

    assign rdata = w_rdata;
    assign ready = r_ready;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter NUM_REGS, default 64: number of 32-bit-class entries; power of two, 2..256.
REQ-002 Parameter DATA_W, default 32: entry width; multiple of 8.
REQ-003 Parameter NRD, default 5: read port count, 1..8.
REQ-004 Parameter NWR, default 2: write port count, 1..4.
REQ-005 Derived AW = $clog2(NUM_REGS); BE_W = DATA_W/8.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 resetn  in  1  reset, asynchronous assert, active-low.
REQ-008 clear  in  1  synchronous request to re-zero all entries.
REQ-009 raddr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW].
REQ-010 rdata  out  NRD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W].
REQ-011 we  in  NWR*BE_W  packed byte write enables, port j at [j*BE_W +: BE_W].
REQ-012 waddr  in  NWR*AW  packed write addresses.
REQ-013 wdata  in  NWR*DATA_W  packed write data.
REQ-014 ready  out  1  high when file is in RUN and accepting writes.

Function
REQ-015 FSM has two states, INIT and RUN.
REQ-016 INIT: internal counter cnt (AW bits) zeroes entry cnt each cycle, cnt increments; on cycle with cnt == NUM_REGS-1, zero that entry, clear cnt, go to RUN.
REQ-017 INIT therefore lasts exactly NUM_REGS cycles; ready rises on the following edge.
REQ-018 RUN: clear sampled high -> go to INIT with cnt = 0, ready low from next cycle.
REQ-019 In INIT, all we inputs are ignored and every rdata port returns 0.
REQ-020 In RUN, for each write port j, byte b of entry waddr[j] takes wdata[j] byte b on the edge when we[j][b] = 1; unenabled bytes hold.
REQ-021 Writes to address 0 are discarded; reads of address 0 return 0 on every port.
REQ-022 Multiple write ports hitting the same address and byte in one cycle: highest port index wins, resolved per byte.
REQ-023 clear high in the same cycle as RUN writes: writes still commit that edge, then INIT zeroes everything.
REQ-024 Read ports are combinational from raddr; any number of ports may read the same address.
REQ-025 All NRD reads and NWR writes proceed in the same cycle without stall.

Reset
REQ-026 resetn low: state = INIT, cnt = 0, ready = 0 immediately; array contents not reset directly.
REQ-027 rdata = 0 on all ports while resetn low and throughout INIT.
REQ-028 resetn asserted mid-INIT or mid-RUN restarts INIT from cnt = 0 after release.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: in RUN, a read whose address matches an active write (non-zero address) returns the new bytes combinationally in the same cycle, using the REQ-022 priority per byte, and stored bytes for unenabled byte lanes.
REQ-030 REGFILE_BYPASS_EN undefined: reads return only stored contents; written data visible from the cycle after the write edge.

Verification
REQ-031 Release resetn, NUM_REGS=64 -> ready low 64 cycles, high on cycle 65; all 5 ports read 0 during that window and after.
REQ-032 RUN: port0 we=4'hF addr 5 data 32'hDEADBEEF, next cycle port1 we=4'b0010 addr 5 data 32'h00001200 -> entry 5 reads 32'hDEAD12EF.
REQ-033 Same cycle: port0 and port1 both we=4'hF addr 7, data 32'h11111111 / 32'h22222222 -> entry 7 reads 32'h22222222; write to addr 0 -> reads 0.
REQ-034 Bypass: write addr 9 data 32'hCAFEF00D we=4'hF, raddr[2]=9 same cycle -> rdata port2 32'hCAFEF00D with REGFILE_BYPASS_EN, old value (0) without.
REQ-035 Fill entries 1..63 with nonzero data, pulse clear -> ready low next cycle for 64 cycles, then every entry reads 0; writes during INIT have no effect.
REQ-036 Assert resetn low at INIT cycle 30 for 2 cycles -> ready stays low, full 64-cycle INIT restarts after release.
